// File: rtl/mod_single_reducer_pkg.sv
// Shared types and ring constants for the RLWE datapath.
`ifndef W_BITS
`define W_BITS 16
`endif
`ifndef N_SLOTS
`define N_SLOTS 8
`endif
`ifndef Q_MOD
`define Q_MOD 7710
`endif
`ifndef T_MOD
`define T_MOD 257
`endif
`ifndef DELTA
`define DELTA (`Q_MOD / `T_MOD)
`endif

package mod_single_reducer_pkg;
   localparam int W_BITS_L  = `W_BITS;
   localparam int N_SLOTS_L = `N_SLOTS;

   typedef logic [W_BITS_L-1:0] word_t;

   localparam word_t Q_MOD_L = word_t'(`Q_MOD);
   localparam word_t T_MOD_L = word_t'(`T_MOD);
   localparam word_t DELTA_L = word_t'(`DELTA);
endpackage

// File: rtl/mod_single_reducer_comb.sv
// Pure combinational signed reduction of a double-width value into [0, Q).
// Truncating remainder followed by a single +Q correction for negative results.
module mod_reduce_comb
   import mod_single_reducer_pkg::*;
#(
   parameter int    W  = W_BITS_L,
   parameter int    WW = 2*W_BITS_L,
   parameter word_t Q  = Q_MOD_L
) (
   input  logic signed [WW-1:0] i_val,
   output logic        [W-1:0]  o_mod
);

   // One extra bit so that the magnitude of -2^(WW-1) is representable.
   localparam logic signed [WW:0] Q_EXT = $signed({{(WW+1-W_BITS_L){1'b0}}, Q});

   logic signed [WW:0] w_ext;
   logic signed [WW:0] w_rem;
   logic signed [WW:0] w_fix;

   assign w_ext = {i_val[WW-1], i_val};

   // Remainder carries the dividend's sign; fold negatives back into [0, Q).
   always_comb begin
      w_rem = w_ext % Q_EXT;
      w_fix = w_rem;
      if (w_rem < 0) begin
         w_fix = w_rem + Q_EXT;
      end
   end

   // w_fix is provably in [0, Q) with Q < 2^(W-1), so the upper bits are zero.
   assign o_mod = W'(w_fix);

endmodule

// File: rtl/mod_single_reducer.sv
// Canonical residue stage: zero-latency combinational result plus a
// one-cycle registered copy with a valid flag for pipelined consumers.
module mod_single_reducer
   import mod_single_reducer_pkg::*;
#(
   parameter int    W  = W_BITS_L,
   parameter int    WW = 2*W_BITS_L,
   parameter word_t Q  = Q_MOD_L
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic signed [WW-1:0] i_in_val,
   input  logic                 i_in_valid,
   output logic        [W-1:0]  o_out_mod,
   output logic        [W-1:0]  o_out_mod_q,
   output logic                 o_out_valid
);

   logic [W-1:0] w_mod;
   logic [W-1:0] r_mod_q;
   logic         r_valid;

   mod_reduce_comb #(
      .W  (W),
      .WW (WW),
      .Q  (Q)
   ) u_core (
      .i_val (i_in_val),
      .o_mod (w_mod)
   );

   // Capture the residue only for qualified inputs; the valid flag follows every cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_mod_q <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= i_in_valid;
         if (i_in_valid) begin
            r_mod_q <= w_mod;
         end
      end
   end

   assign o_out_mod   = w_mod;
   assign o_out_mod_q = r_mod_q;
   assign o_out_valid = r_valid;

endmodule

// File: tb/tb_mod_single_reducer.sv
// Directed bench for mod_single_reducer with Q = 7710, W = 16, WW = 32.
module tb_mod_single_reducer;

   logic               clk;
   logic               rst;
   logic signed [31:0] in_val;
   logic               in_valid;
   logic        [15:0] out_mod;
   logic        [15:0] out_mod_q;
   logic               out_valid;

   int total;
   int bad;

   mod_single_reducer #(
      .W  (16),
      .WW (32),
      .Q  (16'd7710)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_val    (in_val),
      .i_in_valid  (in_valid),
      .o_out_mod   (out_mod),
      .o_out_mod_q (out_mod_q),
      .o_out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic signed [31:0] val;
      logic        [15:0] exp;
   } vec_t;

   task automatic run_comb(input string name, input vec_t v[]);
      foreach (v[i]) begin
         in_val = v[i].val;
         #1;
         total++;
         if (out_mod !== v[i].exp) begin
            bad++;
            $display("FAIL %s[%0d] in=%0d got=%0d want=%0d", name, i, v[i].val, out_mod, v[i].exp);
         end
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_val   = 32'sd0;
      #1;
      total++;
      if (out_mod_q !== 16'd0) begin
         bad++;
         $display("FAIL reset_q got=%0d want=0", out_mod_q);
      end
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_valid got=%0b want=0", out_valid);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_comb_in_range();
      vec_t v[] = '{'{32'sd0, 16'd0}, '{32'sd5, 16'd5}, '{32'sd7709, 16'd7709}};
      run_comb("in_range", v);
   endtask

   task automatic test_comb_pos_wrap();
      vec_t v[] = '{'{32'sd7710, 16'd0}, '{32'sd7711, 16'd1},
                    '{32'sd9041, 16'd1331}, '{32'sd38592, 16'd42}};
      run_comb("pos_wrap", v);
   endtask

   task automatic test_comb_neg();
      vec_t v[] = '{'{-32'sd1, 16'd7709}, '{-32'sd20, 16'd7690},
                    '{-32'sd7717, 16'd7703}, '{-32'sd23115, 16'd15}};
      run_comb("negative", v);
   endtask

   task automatic test_comb_extremes();
      vec_t v[] = '{'{32'sh7FFF_FFFF, 16'd1927}, '{32'sh8000_0000, 16'd5782}};
      run_comb("extremes", v);
   endtask

   task automatic test_registered();
      @(negedge clk);
      in_val   = 32'sd9041;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (out_mod_q !== 16'd1331) begin
         bad++;
         $display("FAIL reg_capture got=%0d want=1331", out_mod_q);
      end
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL reg_valid_hi got=%0b want=1", out_valid);
      end
      @(negedge clk);
      in_val   = -32'sd1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (out_mod_q !== 16'd1331) begin
         bad++;
         $display("FAIL reg_hold got=%0d want=1331", out_mod_q);
      end
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reg_valid_lo got=%0b want=0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      vec_t v[] = '{'{32'sd7711, 16'd1}, '{-32'sd20, 16'd7690}, '{32'sd38592, 16'd42}};
      foreach (v[i]) begin
         @(negedge clk);
         in_val   = v[i].val;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         total++;
         if (out_mod_q !== v[i].exp || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b[%0d] got=%0d/%0b want=%0d/1", i, out_mod_q, out_valid, v[i].exp);
         end
      end
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      in_val   = 32'sd9041;
      in_valid = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (out_mod_q !== 16'd0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset got=%0d/%0b want=0/0", out_mod_q, out_valid);
      end
      total++;
      if (out_mod !== 16'd1331) begin
         bad++;
         $display("FAIL mid_reset_comb got=%0d want=1331", out_mod);
      end
      in_val = -32'sd7717;
      #1;
      total++;
      if (out_mod !== 16'd7703) begin
         bad++;
         $display("FAIL mid_reset_track got=%0d want=7703", out_mod);
      end
      @(posedge clk);
      #1;
      total++;
      if (out_mod_q !== 16'd0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_held got=%0d/%0b want=0/0", out_mod_q, out_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (out_mod_q !== 16'd7703 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL first_capture got=%0d/%0b want=7703/1", out_mod_q, out_valid);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_comb_in_range();
      test_comb_pos_wrap();
      test_comb_neg();
      test_comb_extremes();
      test_registered();
      test_back_to_back();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
